// File: rtl/mem_wb_stage_if.sv
// Data-memory handshake bundle between the MEM stage (master) and data memory (slave).
interface mem_wb_stage_if;
  logic        dmem_en;
  logic        dmem_wr;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_en, dmem_wr, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_en, dmem_wr, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB register of the 16-bit pipelined cpu.
// Optional MEM-to-MEM store-data forwarding is enabled by defining MEM_FWD_EN.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [15:0]           ex_inst,
  input  logic [15:0]           ex_result,
  input  logic [15:0]           ex_store_data,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_reg_write,
  input  logic                  ex_halt,
  output logic                  mem_stall,
  mem_wb_stage_if.master        dmem,
  output logic                  wb_valid,
  output logic [15:0]           wb_inst,
  output logic                  wb_reg_write,
  output logic [3:0]            wb_dst,
  output logic [15:0]           wb_data,
  output logic                  hlt,
  output logic                  mem_err
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state;
  logic [15:0] wait_cnt;
  logic        lat_wr;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic [15:0] lat_inst;
  logic        lat_reg_write;

  logic        accept;
  logic        is_mem;
  logic        req_new;
  logic        in_wait;
  logic        timeout_hit;
  logic [15:0] new_wdata;

  always_comb begin
    // Gating with rst_n drops the request the instant reset asserts.
    accept  = rst_n & ex_valid & ~hlt & (state == StIdle);
    is_mem  = ~ex_halt & (ex_mem_read | ex_mem_write);
    req_new = accept & is_mem;
    in_wait = rst_n & (state == StWait);
    timeout_hit = (TIMEOUT != 0) && in_wait && !dmem.dmem_ready &&
                  (wait_cnt == 16'(TIMEOUT));
`ifdef MEM_FWD_EN
    if (ex_mem_write && (ex_inst[11:8] == wb_dst) && wb_valid && wb_reg_write) begin
      new_wdata = wb_data;
    end else begin
      new_wdata = ex_store_data;
    end
`else
    new_wdata = ex_store_data;
`endif
  end

  always_comb begin
    dmem.dmem_en    = req_new | in_wait;
    dmem.dmem_wr    = in_wait ? lat_wr    : ex_mem_write;
    dmem.dmem_addr  = in_wait ? lat_addr  : ex_result;
    dmem.dmem_wdata = in_wait ? lat_wdata : new_wdata;
    // An aborted access retires, so EX/MEM must advance past it as on a normal completion.
    mem_stall = (req_new & ~dmem.dmem_ready) |
                (in_wait & ~dmem.dmem_ready & ~timeout_hit);
  end

  assign wb_dst = wb_inst[11:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StIdle;
      wait_cnt      <= '0;
      lat_wr        <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      lat_inst      <= '0;
      lat_reg_write <= 1'b0;
      wb_valid      <= 1'b0;
      wb_inst       <= '0;
      wb_reg_write  <= 1'b0;
      wb_data       <= '0;
      hlt           <= 1'b0;
      mem_err       <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_inst      <= '0;
      wb_data      <= '0;
      unique case (state)
        StIdle: begin
          if (accept) begin
            if (is_mem && !dmem.dmem_ready) begin
              state         <= StWait;
              wait_cnt      <= 16'd1;
              lat_wr        <= ex_mem_write;
              lat_addr      <= ex_result;
              lat_wdata     <= new_wdata;
              lat_inst      <= ex_inst;
              lat_reg_write <= ex_reg_write & ~ex_mem_write;
            end else begin
              wb_valid     <= 1'b1;
              wb_inst      <= ex_inst;
              wb_reg_write <= ex_reg_write & ~ex_halt & ~(is_mem & ex_mem_write);
              wb_data      <= (is_mem && !ex_mem_write) ? dmem.dmem_rdata : ex_result;
              if (ex_halt) begin
                hlt <= 1'b1;
              end
            end
          end
        end
        StWait: begin
          if (dmem.dmem_ready) begin
            state        <= StIdle;
            wait_cnt     <= '0;
            wb_valid     <= 1'b1;
            wb_inst      <= lat_inst;
            wb_reg_write <= lat_reg_write;
            wb_data      <= lat_wr ? lat_addr : dmem.dmem_rdata;
          end else if (timeout_hit) begin
            state        <= StIdle;
            wait_cnt     <= '0;
            wb_valid     <= 1'b1;
            wb_inst      <= lat_inst;
            wb_reg_write <= 1'b0;
            wb_data      <= ERR_DATA;
            mem_err      <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus a randomized op stream.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [15:0] ex_inst;
  logic [15:0] ex_result;
  logic [15:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_halt;
  logic        mem_stall;
  logic        wb_valid;
  logic [15:0] wb_inst;
  logic        wb_reg_write;
  logic [3:0]  wb_dst;
  logic [15:0] wb_data;
  logic        hlt;
  logic        mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Last retirement, used to predict store-data forwarding.
  logic        prev_rw;
  logic [3:0]  prev_dst;
  logic [15:0] prev_data;

  mem_wb_stage_if dmem ();

  mem_wb_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_inst       (ex_inst),
    .ex_result     (ex_result),
    .ex_store_data (ex_store_data),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_write  (ex_reg_write),
    .ex_halt       (ex_halt),
    .mem_stall     (mem_stall),
    .dmem          (dmem),
    .wb_valid      (wb_valid),
    .wb_inst       (wb_inst),
    .wb_reg_write  (wb_reg_write),
    .wb_dst        (wb_dst),
    .wb_data       (wb_data),
    .hlt           (hlt),
    .mem_err       (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    ex_valid         = 1'b0;
    ex_inst          = '0;
    ex_result        = '0;
    ex_store_data    = '0;
    ex_mem_read      = 1'b0;
    ex_mem_write     = 1'b0;
    ex_reg_write     = 1'b0;
    ex_halt          = 1'b0;
    dmem.dmem_ready  = 1'b0;
    dmem.dmem_rdata  = '0;
  endtask

  // kind: 0 = ALU, 1 = load, 2 = store. Memory answers after lat cycles.
  // Called just after a rising edge; returns just after the retiring edge.
  task automatic run_op(input int kind, input logic [3:0] dst, input logic [15:0] res,
                        input logic [15:0] sdata, input logic [15:0] rdata, input int lat,
                        input logic [15:0] exp_wdata, input string tag);
    logic [15:0] inst;
    logic [15:0] exp_data;
    inst = {(kind == 0) ? 4'h1 : (kind == 1) ? 4'h8 : 4'h9, dst, 8'($urandom)};
    exp_data = (kind == 1) ? rdata : res;
    ex_valid      = 1'b1;
    ex_inst       = inst;
    ex_result     = res;
    ex_store_data = sdata;
    ex_mem_read   = (kind == 1);
    ex_mem_write  = (kind == 2);
    ex_reg_write  = (kind != 2);
    ex_halt       = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      dmem.dmem_ready = (k == lat);
      dmem.dmem_rdata = (k == lat) ? rdata : 16'($urandom);
      #1;
      n_tests++;
      if (kind != 0) begin
        if ({dmem.dmem_en, dmem.dmem_wr, dmem.dmem_addr, dmem.dmem_wdata} !==
            {1'b1, (kind == 2), res, exp_wdata}) begin
          n_fail++;
          $display("FAIL %s req k=%0d: got en/wr/addr/wdata %b/%b/%h/%h want 1/%b/%h/%h", tag,
                   k, dmem.dmem_en, dmem.dmem_wr, dmem.dmem_addr, dmem.dmem_wdata,
                   (kind == 2), res, exp_wdata);
        end
      end else if (dmem.dmem_en !== 1'b0) begin
        n_fail++;
        $display("FAIL %s dmem_en: got %b want 0", tag, dmem.dmem_en);
      end
      n_tests++;
      if (mem_stall !== (kind != 0 && k < lat)) begin
        n_fail++;
        $display("FAIL %s stall k=%0d: got %b want %b", tag, k, mem_stall, (kind != 0 && k < lat));
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (k < lat) begin
        if ({wb_valid, wb_reg_write} !== 2'b00) begin
          n_fail++;
          $display("FAIL %s bubble k=%0d: got valid/rw %b/%b want 0/0", tag, k, wb_valid,
                   wb_reg_write);
        end
      end else if ({wb_valid, wb_reg_write, wb_dst, wb_inst, wb_data} !==
                   {1'b1, (kind != 2), dst, inst, exp_data}) begin
        n_fail++;
        $display("FAIL %s retire: got v/rw/dst/inst/data %b/%b/%h/%h/%h want 1/%b/%h/%h/%h",
                 tag, wb_valid, wb_reg_write, wb_dst, wb_inst, wb_data, (kind != 2), dst,
                 inst, exp_data);
      end
    end
    prev_rw   = (kind != 2);
    prev_dst  = dst;
    prev_data = exp_data;
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    ex_valid = 1'b1;
    ex_mem_write = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({wb_valid, wb_reg_write, wb_inst, wb_data, hlt, mem_err, dmem.dmem_en, mem_stall} !== '0)
    begin
      n_fail++;
      $display("FAIL reset: got v/rw/inst/data/hlt/err/en/stall %b/%b/%h/%h/%b/%b/%b/%b want 0",
               wb_valid, wb_reg_write, wb_inst, wb_data, hlt, mem_err, dmem.dmem_en, mem_stall);
    end
    drive_idle();
    rst_n = 1'b1;
    prev_rw = 1'b0;
  endtask

  task automatic test_alu();
    run_op(0, 4'd3, 16'h0012, 16'h0, 16'h0, 0, 16'h0, "add");
  endtask

  task automatic test_load_fast();
    run_op(1, 4'd2, 16'h0040, 16'h0, 16'hBEEF, 0, 16'h0, "lw_fast");
  endtask

  task automatic test_store_wait();
    run_op(2, 4'd7, 16'h0010, 16'h1234, 16'h0, 3, 16'h1234, "sw_wait");
  endtask

  task automatic test_timeout();
    ex_valid     = 1'b1;
    ex_inst      = 16'h8400;
    ex_result    = 16'h0050;
    ex_mem_read  = 1'b1;
    ex_reg_write = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (dmem.dmem_en !== 1'b1 || (k < 15 && mem_stall !== 1'b1)) begin
        n_fail++;
        $display("FAIL timeout req k=%0d: got en/stall %b/%b want 1/1", k, dmem.dmem_en,
                 mem_stall);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (k < 15) begin
        if ({wb_valid, mem_err} !== 2'b00) begin
          n_fail++;
          $display("FAIL timeout wait k=%0d: got valid/err %b/%b want 0/0", k, wb_valid, mem_err);
        end
      end else if ({wb_valid, wb_reg_write, wb_data, mem_err} !== {1'b1, 1'b0, 16'hDEAD, 1'b1})
      begin
        n_fail++;
        $display("FAIL timeout abort: got v/rw/data/err %b/%b/%h/%b want 1/0/dead/1", wb_valid,
                 wb_reg_write, wb_data, mem_err);
      end
    end
    drive_idle();
    @(negedge clk);
    #1;
    n_tests++;
    if ({dmem.dmem_en, mem_err} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout after: got en/err %b/%b want 0/1", dmem.dmem_en, mem_err);
    end
    @(posedge clk);
    #1;
    run_op(0, 4'd9, 16'h7777, 16'h0, 16'h0, 0, 16'h0, "after_timeout");
  endtask

  task automatic test_reset_mid_access();
    ex_valid      = 1'b1;
    ex_inst       = 16'h9100;
    ex_result     = 16'h0AA0;
    ex_mem_write  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({dmem.dmem_en, mem_stall, wb_valid, mem_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid: got en/stall/valid/err %b/%b/%b/%b want 0/0/0/0", dmem.dmem_en,
               mem_stall, wb_valid, mem_err);
    end
    drive_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_rw = 1'b0;
  endtask

  task automatic test_halt();
    ex_valid     = 1'b1;
    ex_inst      = 16'hF000;
    ex_halt      = 1'b1;
    ex_reg_write = 1'b1;
    ex_result    = 16'h1111;
    @(posedge clk);
    #1;
    n_tests++;
    if ({hlt, wb_valid, wb_reg_write} !== 3'b110) begin
      n_fail++;
      $display("FAIL halt retire: got hlt/v/rw %b/%b/%b want 1/1/0", hlt, wb_valid, wb_reg_write);
    end
    ex_halt     = 1'b0;
    ex_inst     = 16'h1300;
    ex_mem_read = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      dmem.dmem_ready = 1'b1;
      #1;
      n_tests++;
      if ({dmem.dmem_en, mem_stall} !== 2'b00) begin
        n_fail++;
        $display("FAIL halt block k=%0d: got en/stall %b/%b want 0/0", k, dmem.dmem_en, mem_stall);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if ({wb_valid, wb_reg_write, hlt} !== 3'b001) begin
        n_fail++;
        $display("FAIL halt after k=%0d: got v/rw/hlt %b/%b/%b want 0/0/1", k, wb_valid,
                 wb_reg_write, hlt);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (hlt !== 1'b0) begin
      n_fail++;
      $display("FAIL halt reset: got %b want 0", hlt);
    end
    drive_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_rw = 1'b0;
  endtask

  task automatic test_forward();
    logic [15:0] exp_w;
`ifdef MEM_FWD_EN
    exp_w = 16'h00AA;
`else
    exp_w = 16'h5555;
`endif
    run_op(1, 4'd5, 16'h0030, 16'h0, 16'h00AA, 1, 16'h0, "fwd_lw");
    run_op(2, 4'd5, 16'h0020, 16'h5555, 16'h0, 2, exp_w, "fwd_sw");
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    #1;
    prev_rw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int          kind;
      int          lat;
      logic [3:0]  dst;
      logic [15:0] sdata;
      logic [15:0] exp_w;
      kind  = int'($urandom_range(2, 0));
      lat   = (kind == 0) ? 0 : int'($urandom_range(4, 0));
      dst   = 4'($urandom);
      sdata = 16'($urandom);
      exp_w = sdata;
`ifdef MEM_FWD_EN
      if (kind == 2 && prev_rw && prev_dst == dst) exp_w = prev_data;
`endif
      run_op(kind, dst, 16'($urandom), sdata, 16'($urandom), lat, exp_w, "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load_fast();
    test_store_wait();
    test_forward();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    test_halt();
    test_alu();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
